nes_pad_responder: RTL and testbench

// - Device side of the NES controller serial protocol: emulates a 4021-based pad.
// - Answers an external host's latch and ctrl_clk pulses with the 8 button bits on data.
// - Pairs with the controller reader. Used for loopback bench rigs and for exposing game state to a second board.

---
 rtl/nes_pad_pkg.sv | 23 ++
 rtl/nes_pad_responder_sync_edge.sv | 39 +++
 rtl/nes_pad_responder.sv | 138 +++++++++++++
 tb/tb_nes_pad_responder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pad_pkg.sv
// NES pad protocol constants shared by the pad responder and the controller reader.
// Button order matches the shift-out order of a 4021 pad.
package nes_pad_pkg;

  localparam int NES_FRAME_BITS = 8;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  typedef enum logic [1:0] {
    PAD_IDLE,
    PAD_LOAD,
    PAD_SHIFT,
    PAD_DONE
  } pad_state_t;

endpackage

// File: rtl/nes_pad_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous host pin.
// Level, rise and fall outputs are registered together so they stay aligned.
module sync_edge
  import nes_pad_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              lvl_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      lvl_q  <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~lvl_q;
      fall_q <= ~sync_q[STAGES-1] & lvl_q;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/nes_pad_responder.sv
// Device side of the NES pad serial protocol (4021 emulation).
// Answers host latch / ctrl_clk pulses with button bits on data.
module nes_pad_responder
  import nes_pad_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       latch,
  input  logic       ctrl_clk,
  input  logic [7:0] buttons,
  output logic       data,
  output logic       frame_done,
  output logic       shifting,
  output logic [2:0] bit_idx,
  output logic       poll_stale
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  localparam logic [2:0] LAST = 3'(NES_FRAME_BITS - 1);

  logic lat_lvl, lat_rise, lat_fall;
  logic ck_lvl, ck_rise, ck_fall;
  logic unused_ck;

  sync_edge #(.STAGES(SYNC_STAGES)) u_lat_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (latch),
    .level_o (lat_lvl),
    .rise_o  (lat_rise),
    .fall_o  (lat_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_ck_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (ctrl_clk),
    .level_o (ck_lvl),
    .rise_o  (ck_rise),
    .fall_o  (ck_fall)
  );

  assign unused_ck = ^{ck_lvl, ck_fall};

  pad_state_t state_q, state_d;

  logic [NES_FRAME_BITS-1:0] sr_q, sr_d;
  logic [2:0]                idx_q, idx_d;
  logic                      fd_q, fd_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic in_shift;
  logic shift_en;
  logic frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PAD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (lat_rise) begin
      state_d = PAD_LOAD;
    end else begin
      unique case (state_q)
        PAD_IDLE:  state_d = PAD_IDLE;
        PAD_LOAD:  if (lat_fall) state_d = PAD_SHIFT;
        PAD_SHIFT: if (frame_end) state_d = PAD_DONE;
        PAD_DONE:  state_d = PAD_DONE;
        default:   state_d = PAD_IDLE;
      endcase
    end
  end

  // A high latch masks clock edges, so the latch always wins a tie.
  always_comb begin
    in_shift  = (state_q == PAD_SHIFT);
    shift_en  = in_shift & ck_rise & ~lat_lvl;
    frame_end = shift_en & (idx_q == LAST);
  end

  always_comb begin
    sr_d = sr_q;
    unique case (1'b1)
      lat_lvl:  sr_d = ~buttons;
      shift_en: sr_d = {sr_q[NES_FRAME_BITS-2:0], 1'b0};
      default:  sr_d = sr_q;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if (lat_rise || (state_q == PAD_LOAD && lat_fall)) begin
      idx_d = '0;
    end else if (shift_en) begin
      idx_d = idx_q + 3'd1;
    end
  end

  always_comb begin
    fd_d  = frame_end;
    cnt_d = cnt_q;
    if (lat_fall) begin
      cnt_d = '0;
    end else if (cnt_q != TMO) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '1;
      idx_q <= '0;
      fd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
      fd_q  <= fd_d;
      cnt_q <= cnt_d;
    end
  end

  assign data       = sr_q[BTN_A];
  assign frame_done = fd_q;
  assign shifting   = in_shift;
  assign bit_idx    = idx_q;
  assign poll_stale = (cnt_q == TMO);

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder: protocol-level model
// plus directed frames and randomized host traffic.
module tb_nes_pad_responder;

  localparam int S   = 2;
  localparam int TMO = 100;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_SHIFT = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       latch = 1'b0;
  logic       ctrl_clk = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       data;
  logic       frame_done;
  logic       shifting;
  logic [2:0] bit_idx;
  logic       poll_stale;

  nes_pad_responder #(
    .SYNC_STAGES    (S),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .latch      (latch),
    .ctrl_clk   (ctrl_clk),
    .buttons    (buttons),
    .data       (data),
    .frame_done (frame_done),
    .shifting   (shifting),
    .bit_idx    (bit_idx),
    .poll_stale (poll_stale)
  );

  always #5 clk = ~clk;

  int vecs   = 0;
  int errs   = 0;
  int fd_cnt = 0;

  // Host pins as seen by the control logic: pin history, S+1 edges late.
  logic       lp [0:S+2];
  logic       cp [0:S+2];
  int         ph;
  int         n;
  logic [7:0] word;
  int         tcnt;
  logic       e_fd;

  always @(posedge clk or negedge rst_n) begin
    logic el, lr, lf, cr, sh;
    if (!rst_n) begin
      for (int i = 0; i <= S + 2; i++) begin
        lp[i] = 1'b0;
        cp[i] = 1'b0;
      end
      ph   = M_IDLE;
      n    = 0;
      word = 8'h00;
      tcnt = 0;
      e_fd = 1'b0;
    end else begin
      for (int i = S + 2; i > 0; i--) begin
        lp[i] = lp[i-1];
        cp[i] = cp[i-1];
      end
      lp[0] = latch;
      cp[0] = ctrl_clk;
      el = lp[S+1];
      lr = el & ~lp[S+2];
      lf = ~el & lp[S+2];
      cr = cp[S+1] & ~cp[S+2];
      sh = (ph == M_SHIFT) && cr && !el;
      e_fd = 1'b0;
      if (lr) begin
        ph = M_LOAD;
        n  = 0;
      end else if (ph == M_LOAD && lf) begin
        ph = M_SHIFT;
        n  = 0;
      end else if (sh) begin
        n++;
        if (n == 8) begin
          ph   = M_DONE;
          e_fd = 1'b1;
        end
      end
      if (el) word = buttons;
      if (lf) tcnt = 0;
      else if (tcnt < TMO) tcnt++;
    end
  end

  always @(negedge clk) begin
    logic e_data, e_sh, e_st;
    logic [2:0] e_idx;
    if (rst_n) begin
      if (ph == M_IDLE) e_data = 1'b1;
      else if (n >= 8) e_data = 1'b0;
      else e_data = ~word[7-n];
      e_idx = 3'(n % 8);
      e_sh  = (ph == M_SHIFT);
      e_st  = (tcnt >= TMO);
      vecs++;
      if (data !== e_data) begin
        errs++;
        $display("FAIL data got %b exp %b @%0t", data, e_data, $time);
      end
      if (frame_done !== e_fd) begin
        errs++;
        $display("FAIL frame_done got %b exp %b @%0t",
                 frame_done, e_fd, $time);
      end
      if (shifting !== e_sh) begin
        errs++;
        $display("FAIL shifting got %b exp %b @%0t",
                 shifting, e_sh, $time);
      end
      if (bit_idx !== e_idx) begin
        errs++;
        $display("FAIL bit_idx got %0d exp %0d @%0t",
                 bit_idx, e_idx, $time);
      end
      if (poll_stale !== e_st) begin
        errs++;
        $display("FAIL poll_stale got %b exp %b @%0t",
                 poll_stale, e_st, $time);
      end
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_latch(input int w);
    latch = 1'b1;
    cyc(w);
    latch = 1'b0;
    cyc(6);
  endtask

  task automatic pulse_ckw(input int hi, input int lo, output logic smp);
    smp = data;
    ctrl_clk = 1'b1;
    cyc(hi);
    ctrl_clk = 1'b0;
    cyc(lo);
  endtask

  task automatic pulse_ck(output logic smp);
    pulse_ckw(6, 6, smp);
  endtask

  initial begin
    #1_000_000;
    errs++;
    $display("FAIL watchdog: run did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    logic s;
    logic [7:0] exp_bits;
    int f0;

    cyc(3);
    chk("rst_data", data, 1);
    chk("rst_fd", frame_done, 0);
    chk("rst_shifting", shifting, 0);
    chk("rst_idx", bit_idx, 0);
    chk("rst_stale", poll_stale, 0);
    #2 rst_n = 1'b1;

    cyc(99);
    chk("stale_99", poll_stale, 0);
    cyc(1);
    chk("stale_100", poll_stale, 1);

    pulse_ck(s);
    pulse_ck(s);
    chk("idle_ck_data", data, 1);
    chk("idle_ck_shift", shifting, 0);

    // A and Right pressed
    buttons = 8'b1000_0001;
    f0 = fd_cnt;
    pulse_latch(12);
    chk("stale_clear", poll_stale, 0);
    chk("shift_entered", shifting, 1);
    exp_bits = 8'b0111_1110;
    for (int i = 0; i < 8; i++) begin
      pulse_ck(s);
      chk($sformatf("frame_bit%0d", i), s, exp_bits[7-i]);
    end
    chk("frame_done_once", 8'(fd_cnt - f0), 1);
    chk("done_data", data, 0);
    pulse_ck(s);
    pulse_ck(s);
    chk("extra_ck_data", data, 0);
    chk("extra_ck_fd", 8'(fd_cnt - f0), 1);

    // Re-latch after three shifts aborts the frame
    buttons = 8'h5A;
    pulse_latch(10);
    for (int i = 0; i < 3; i++) pulse_ck(s);
    f0 = fd_cnt;
    buttons = 8'h3C;
    latch = 1'b1;
    cyc(6);
    chk("relatch_shift", shifting, 0);
    chk("relatch_idx", bit_idx, 0);
    chk("relatch_data", data, 1);
    latch = 1'b0;
    cyc(6);
    chk("relatch_no_fd", 8'(fd_cnt - f0), 0);
    for (int i = 0; i < 8; i++) pulse_ck(s);
    chk("relatch_full_fd", 8'(fd_cnt - f0), 1);

    // Transparent load while latch is high
    buttons = 8'h00;
    latch = 1'b1;
    cyc(6);
    buttons = 8'h80;
    cyc(S + 2);
    chk("track_press", data, 0);
    buttons = 8'h00;
    cyc(S + 2);
    chk("track_release", data, 1);
    buttons = 8'hC0;
    cyc(4);
    latch = 1'b0;
    cyc(6);
    buttons = 8'h3F;
    pulse_ck(s);
    chk("inflight_b0", s, 0);
    pulse_ck(s);
    chk("inflight_b1", s, 0);
    pulse_ck(s);
    chk("inflight_b2", s, 1);
    for (int i = 0; i < 5; i++) pulse_ck(s);

    // Latch and ctrl_clk rising together
    buttons = 8'h7F;
    latch = 1'b1;
    ctrl_clk = 1'b1;
    cyc(6);
    ctrl_clk = 1'b0;
    cyc(6);
    latch = 1'b0;
    cyc(6);
    chk("tie_idx", bit_idx, 0);
    chk("tie_shift", shifting, 1);
    pulse_ck(s);
    chk("tie_bitA", s, 1);
    pulse_ck(s);
    chk("tie_bitB", s, 0);
    for (int i = 0; i < 6; i++) pulse_ck(s);

    // Reset in the middle of a frame
    buttons = 8'h81;
    pulse_latch(8);
    for (int i = 0; i < 3; i++) pulse_ck(s);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data", data, 1);
    chk("midrst_fd", frame_done, 0);
    chk("midrst_shift", shifting, 0);
    chk("midrst_idx", bit_idx, 0);
    chk("midrst_stale", poll_stale, 0);
    cyc(2);
    #2 rst_n = 1'b1;
    cyc(3);
    chk("postrst_data", data, 1);

    // Randomized host traffic
    for (int it = 0; it < 120; it++) begin
      int act;
      act = int'($urandom_range(0, 9));
      if (act <= 1) begin
        pulse_latch(int'($urandom_range(3, 15)));
      end else if (act <= 6) begin
        pulse_ckw(int'($urandom_range(3, 8)),
                  int'($urandom_range(3, 8)), s);
      end else if (act == 7) begin
        buttons = 8'($urandom);
        cyc(int'($urandom_range(1, 4)));
      end else if (act == 8) begin
        latch = 1'b1;
        cyc(int'($urandom_range(3, 6)));
        buttons = 8'($urandom);
        pulse_ckw(3, 3, s);
        latch = 1'b0;
        cyc(int'($urandom_range(3, 6)));
      end else begin
        cyc(int'($urandom_range(20, 60)));
      end
    end
    cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
